// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared hart types: register index, MMIO wait states and the
// stall/bubble/hold bundle that gates the pipeline registers.
package pipeline_hazard_controller_pkg;

    localparam int XLEN = 32;
    localparam int NUM_REGS = 32;
    localparam int SB_CNT_W = 2;

    typedef logic [4:0] rv_reg_t;

    typedef enum logic [0:0] {
        MMIO_IDLE = 1'b0,
        MMIO_WAIT = 1'b1
    } mmio_wait_state_t;

    typedef struct packed {
        logic stall_front;
        logic bubble_s3;
        logic hold_back;
    } hazard_ctrl_t;

    function automatic logic is_x0(input rv_reg_t r);
        return r == '0;
    endfunction

endpackage

// File: rtl/pipeline_hazard_controller_reg_scoreboard.sv
// Per-register in-flight write counters for x1..x31; x0 is never busy.
// A same-cycle increment and decrement of one register cancel out.
import pipeline_hazard_controller_pkg::*;

module reg_scoreboard (
    input  logic       clock,
    input  logic       reset,
    input  logic       inc_en,
    input  logic [4:0] inc_rd,
    input  logic       dec_en,
    input  logic [4:0] dec_rd,
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    output logic       rs1_busy,
    output logic       rs2_busy
);

    logic [NUM_REGS-1:0] busy;

    assign busy[0] = 1'b0;

    for (genvar i = 1; i < NUM_REGS; i++) begin : g_cnt
        logic [SB_CNT_W-1:0] cnt_q;
        logic [SB_CNT_W-1:0] cnt_d;
        logic                inc;
        logic                dec;

        assign inc = inc_en && (inc_rd == 5'(i));
        assign dec = dec_en && (dec_rd == 5'(i));

        always_comb begin
            cnt_d = cnt_q;
            if (inc && !dec) begin
                cnt_d = cnt_q + SB_CNT_W'(1);
            end else if (dec && !inc) begin
                cnt_d = cnt_q - SB_CNT_W'(1);
            end
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign busy[i] = (cnt_q != '0);

        // At most three writes to one register may be in flight.
        a_no_ovf: assert property (@(posedge clock) disable iff (reset)
            !(inc && !dec && (cnt_q == 2'd3)))
            else $error("scoreboard overflow on x%0d", i);

        a_no_unf: assert property (@(posedge clock) disable iff (reset)
            !(dec && !inc && (cnt_q == 2'd0)))
            else $error("scoreboard underflow on x%0d", i);
    end

    assign rs1_busy = busy[rs1];
    assign rs2_busy = busy[rs2];

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Hart hazard control: RAW stall/bubble, MMIO write freeze with timeout.
// Optional perf counters when HAZARD_PERF_COUNTERS_EN is defined.
import pipeline_hazard_controller_pkg::*;

module pipeline_hazard_controller #(
    parameter int MMIO_TIMEOUT = 255,
    parameter int TIMEOUT_W    = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        issue_valid,
    input  logic        issue_uses_rs1,
    input  logic        issue_uses_rs2,
    input  logic [4:0]  issue_rs1,
    input  logic [4:0]  issue_rs2,
    input  logic        issue_rd_en,
    input  logic [4:0]  issue_rd,
    input  logic        jump_taken,
    input  logic        retire_en,
    input  logic [4:0]  retire_rd,
    input  logic        mmio_w_start,
    input  logic        mmio_write_complete,
    output logic        stall_front,
    output logic        bubble_s3,
    output logic        hold_back,
    output logic        mmio_timeout_err
`ifdef HAZARD_PERF_COUNTERS_EN
    ,
    output logic [31:0] perf_raw_stall_cycles,
    output logic [31:0] perf_mmio_wait_cycles,
    output logic [31:0] perf_squashes
`endif
);

    localparam logic [0:0] ST_IDLE = MMIO_IDLE;
    localparam logic [0:0] ST_WAIT = MMIO_WAIT;
    localparam logic [TIMEOUT_W-1:0] TMO = TIMEOUT_W'(MMIO_TIMEOUT);

    logic [0:0]           state_q;
    logic [0:0]           state_d;
    logic [TIMEOUT_W-1:0] wait_cnt_q;
    logic [TIMEOUT_W-1:0] wait_cnt_d;
    logic                 err_q;
    logic                 err_d;

    hazard_ctrl_t ctrl;
    logic         rs1_busy;
    logic         rs2_busy;
    logic         hazard;
    logic         raw_stall;
    logic         issue_fire;
    logic         inc_en;
    logic         dec_en;

    assign hazard = issue_valid
                  & ((issue_uses_rs1 & rs1_busy)
                  |  (issue_uses_rs2 & rs2_busy));

    // A redirect squashes the stalled instruction, so it wins over the hazard.
    assign raw_stall = hazard & ~jump_taken;

    always_comb begin
        ctrl.hold_back   = (state_q == ST_WAIT);
        ctrl.stall_front = raw_stall | ctrl.hold_back;
        ctrl.bubble_s3   = raw_stall & ~ctrl.hold_back;
    end

    assign issue_fire = issue_valid & ~jump_taken
                      & ~ctrl.stall_front & ~ctrl.hold_back;
    assign inc_en = issue_fire & issue_rd_en;
    assign dec_en = retire_en & ~ctrl.hold_back;

    reg_scoreboard u_sb (
        .clock    (clock),
        .reset    (reset),
        .inc_en   (inc_en),
        .inc_rd   (issue_rd),
        .dec_en   (dec_en),
        .dec_rd   (retire_rd),
        .rs1      (issue_rs1),
        .rs2      (issue_rs2),
        .rs1_busy (rs1_busy),
        .rs2_busy (rs2_busy)
    );

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        err_d      = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (mmio_w_start && !mmio_write_complete) begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = TIMEOUT_W'(1);
                end
            end
            ST_WAIT: begin
                // Completion on the final cycle still counts as success.
                if (mmio_write_complete) begin
                    state_d    = ST_IDLE;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == TMO) begin
                    state_d    = ST_IDLE;
                    wait_cnt_d = '0;
                    err_d      = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + TIMEOUT_W'(1);
                end
            end
            default: begin
                state_d    = ST_IDLE;
                wait_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

    assign stall_front      = ctrl.stall_front;
    assign bubble_s3        = ctrl.bubble_s3;
    assign hold_back        = ctrl.hold_back;
    assign mmio_timeout_err = err_q;

`ifdef HAZARD_PERF_COUNTERS_EN
    logic [31:0] perf_raw_q;
    logic [31:0] perf_raw_d;
    logic [31:0] perf_wait_q;
    logic [31:0] perf_wait_d;
    logic [31:0] perf_sq_q;
    logic [31:0] perf_sq_d;

    always_comb begin
        perf_raw_d  = perf_raw_q  + 32'(raw_stall);
        perf_wait_d = perf_wait_q + 32'(ctrl.hold_back);
        perf_sq_d   = perf_sq_q   + 32'(jump_taken);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            perf_raw_q  <= '0;
            perf_wait_q <= '0;
            perf_sq_q   <= '0;
        end else begin
            perf_raw_q  <= perf_raw_d;
            perf_wait_q <= perf_wait_d;
            perf_sq_q   <= perf_sq_d;
        end
    end

    assign perf_raw_stall_cycles = perf_raw_q;
    assign perf_mmio_wait_cycles = perf_wait_q;
    assign perf_squashes         = perf_sq_q;
`endif

endmodule
